// File: rtl/pkt_switch.sv
// pkt_switch
// -----------------------------------------------------------------------------
// N-port packet switch. Byte-serial packets arrive on one framed input; the
// first byte (DA) is compared against the per-port address registers and the
// whole packet is steered into the FIFO of the lowest-index matching port.
// Each FIFO is written speculatively through a tentative write pointer and
// only committed at end of packet, so an output port only ever presents
// complete, accepted packets. Failed packets (no match, overflow, bad
// trailing parity) are rolled back and counted.
//
// Ports:
//   clock, reset          clock (rising edge), asynchronous active-low reset
//   mem_en/mem_rd_wr      config strobe and direction (1 = write)
//   mem_add/mem_data      port index and address value to write
//   mem_rdata             registered config read data
//   data_status/data_in   packet framing (high for every byte) and byte
//   data_out/out_eop      per-port popped byte and last-byte flag
//   ready                 per-port "holds at least one committed byte"
//   read                  per-port pop request
//   drop_cnt/perr_cnt     saturating drop and parity-error packet counters
// -----------------------------------------------------------------------------
module pkt_switch #(
    parameter int NUM_PORTS    = 4,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 64,
    parameter int CHECK_PARITY = 0,
    parameter int AW           = $clog2(NUM_PORTS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        mem_en,
    input  logic                        mem_rd_wr,
    input  logic [AW-1:0]               mem_add,
    input  logic [DATA_W-1:0]           mem_data,
    output logic [DATA_W-1:0]           mem_rdata,
    input  logic                        data_status,
    input  logic [DATA_W-1:0]           data_in,
    output logic [NUM_PORTS*DATA_W-1:0] data_out,
    output logic [NUM_PORTS-1:0]        out_eop,
    output logic [NUM_PORTS-1:0]        ready,
    input  logic [NUM_PORTS-1:0]        read,
    output logic [15:0]                 drop_cnt,
    output logic [15:0]                 perr_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    typedef logic [PW:0] ptr_t;
    localparam ptr_t FULL_LVL = ptr_t'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t              r_state;
    state_t              w_nextState;

    logic [DATA_W-1:0]   r_addr [NUM_PORTS];
    logic [DATA_W-1:0]   r_rdata;
    logic [DATA_W:0]     r_mem [NUM_PORTS][FIFO_DEPTH];
    ptr_t                r_twp [NUM_PORTS];
    ptr_t                r_cwp [NUM_PORTS];
    ptr_t                r_rp  [NUM_PORTS];
    logic [DATA_W-1:0]   r_dout [NUM_PORTS];
    logic [NUM_PORTS-1:0] r_eop;
    logic [NUM_PORTS-1:0] w_ready;

    logic [AW-1:0]       r_target;
    logic [DATA_W-1:0]   r_xor;
    logic [DATA_W-1:0]   r_lastByte;
    logic                r_multi;
    logic                r_rbPending;
    logic [15:0]         r_dropCnt;
    logic [15:0]         r_perrCnt;

    logic                w_hit;
    logic [AW-1:0]       w_hitIdx;
    logic [AW-1:0]       w_wrPort;
    logic                w_full;
    logic                w_cfgValid;
    logic [DATA_W-1:0]   w_cfgRd;
    logic [PW-1:0]       w_lastIdx;
    logic                w_parityBad;

    logic w_wrByte, w_start, w_setRb, w_rollback, w_commit, w_markEop;
    logic w_incDrop, w_incPerr;

    // Address match: scanning from the top down leaves the lowest index winning.
    always_comb begin
        w_hit    = 1'b0;
        w_hitIdx = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (r_addr[i] == data_in) begin
                w_hit    = 1'b1;
                w_hitIdx = AW'(i);
            end
        end
    end

    // Config read mux; indices past the last port read as zero.
    always_comb begin
        w_cfgRd = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mem_add == AW'(i)) begin
                w_cfgRd = r_addr[i];
            end
        end
    end

    assign w_cfgValid  = (int'(mem_add) < NUM_PORTS);
    assign w_wrPort    = (r_state == IDLE) ? w_hitIdx : r_target;
    // Fullness is judged against the read pointer, so speculative bytes count.
    assign w_full      = ((r_twp[w_wrPort] - r_rp[w_wrPort]) == FULL_LVL);
    assign w_lastIdx   = r_twp[r_target][PW-1:0] - PW'(1);
    // Running XOR covers every byte including the trailer, so a good packet folds to zero.
    assign w_parityBad = (CHECK_PARITY != 0) && ((r_xor != '0) || !r_multi);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Input framing FSM: decides per cycle whether a byte is written, and
    // whether the packet in flight is committed, rolled back or counted.
    always_comb begin
        w_nextState = r_state;
        w_wrByte    = 1'b0;
        w_start     = 1'b0;
        w_setRb     = 1'b0;
        w_rollback  = 1'b0;
        w_commit    = 1'b0;
        w_markEop   = 1'b0;
        w_incDrop   = 1'b0;
        w_incPerr   = 1'b0;
        case (r_state)
            IDLE: begin
                if (data_status) begin
                    w_start = 1'b1;
                    if (w_hit && !w_full) begin
                        w_wrByte    = 1'b1;
                        w_nextState = RECV;
                    end else begin
                        w_setRb     = w_hit;
                        w_nextState = DROP;
                    end
                end
            end
            RECV: begin
                if (data_status) begin
                    if (!w_full) begin
                        w_wrByte = 1'b1;
                    end else begin
                        w_setRb     = 1'b1;
                        w_nextState = DROP;
                    end
                end else begin
                    w_nextState = IDLE;
                    if (w_parityBad) begin
                        w_rollback = 1'b1;
                        w_incPerr  = 1'b1;
                    end else begin
                        w_commit  = 1'b1;
                        w_markEop = 1'b1;
                    end
                end
            end
            DROP: begin
                if (!data_status) begin
                    w_rollback  = r_rbPending;
                    w_incDrop   = 1'b1;
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Per-packet bookkeeping, address registers, config readback and counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_addr[i] <= '0;
            end
            r_rdata     <= '0;
            r_target    <= '0;
            r_xor       <= '0;
            r_lastByte  <= '0;
            r_multi     <= 1'b0;
            r_rbPending <= 1'b0;
            r_dropCnt   <= '0;
            r_perrCnt   <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (mem_en && mem_rd_wr && w_cfgValid && mem_add == AW'(i)) begin
                    r_addr[i] <= mem_data;
                end
            end
            if (mem_en && !mem_rd_wr) begin
                r_rdata <= w_cfgValid ? w_cfgRd : '0;
            end
            if (w_start) begin
                r_target    <= w_hitIdx;
                r_xor       <= data_in;
                r_multi     <= 1'b0;
                r_rbPending <= w_setRb;
            end else begin
                if (w_wrByte) begin
                    r_xor   <= r_xor ^ data_in;
                    r_multi <= 1'b1;
                end
                if (w_setRb) begin
                    r_rbPending <= 1'b1;
                end
            end
            if (w_wrByte) begin
                r_lastByte <= data_in;
            end
            if (w_incDrop && r_dropCnt != 16'hFFFF) begin
                r_dropCnt <= r_dropCnt + 16'd1;
            end
            if (w_incPerr && r_perrCnt != 16'hFFFF) begin
                r_perrCnt <= r_perrCnt + 16'd1;
            end
        end
    end

    // FIFO storage. The eop flag is set by rewriting the last entry at commit
    // time, which never collides with a byte write since none happens then.
    always_ff @(posedge clock) begin
        if (w_wrByte) begin
            r_mem[w_wrPort][r_twp[w_wrPort][PW-1:0]] <= {1'b0, data_in};
        end else if (w_markEop) begin
            r_mem[r_target][w_lastIdx] <= {1'b1, r_lastByte};
        end
    end

    // Per-port pointers and the pop path.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                r_twp[i]  <= '0;
                r_cwp[i]  <= '0;
                r_rp[i]   <= '0;
                r_dout[i] <= '0;
            end
            r_eop <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (w_rollback && r_target == AW'(i)) begin
                    r_twp[i] <= r_cwp[i];
                end else if (w_wrByte && w_wrPort == AW'(i)) begin
                    r_twp[i] <= r_twp[i] + ptr_t'(1);
                end
                if (w_commit && r_target == AW'(i)) begin
                    r_cwp[i] <= r_twp[i];
                end
                if (read[i] && w_ready[i]) begin
                    r_rp[i]   <= r_rp[i] + ptr_t'(1);
                    r_dout[i] <= r_mem[i][r_rp[i][PW-1:0]][DATA_W-1:0];
                    r_eop[i]  <= r_mem[i][r_rp[i][PW-1:0]][DATA_W];
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        assign w_ready[g]                    = (r_cwp[g] != r_rp[g]);
        assign data_out[g*DATA_W +: DATA_W]  = r_dout[g];
    end

    assign ready     = w_ready;
    assign out_eop   = r_eop;
    assign mem_rdata = r_rdata;
    assign drop_cnt  = r_dropCnt;
    assign perr_cnt  = r_perrCnt;

endmodule

// File: tb/tb_pkt_switch.sv
// tb_pkt_switch
// Two switches (parity checking off / on, 5 ports, 8-deep FIFOs) share one
// set of inputs. A queue-based model of the switch's packet rules predicts
// every output each cycle; directed sequences add literal expectations.
module tb_pkt_switch;

    localparam int NP    = 5;
    localparam int DEPTH = 8;

    logic        clock;
    logic        resetN;
    logic        memEn;
    logic        memRdWr;
    logic [2:0]  memAdd;
    logic [7:0]  memData;
    logic        dataStatus;
    logic [7:0]  dataIn;
    logic [4:0]  readReq;

    logic [7:0]  memRdata [2];
    logic [39:0] dataOut  [2];
    logic [4:0]  outEop   [2];
    logic [4:0]  readyV   [2];
    logic [15:0] dropCnt  [2];
    logic [15:0] perrCnt  [2];

    int nChecks = 0;
    int nPass   = 0;

    // Clock generation
    initial clock = 1'b0;
    always #5 clock = ~clock;

    pkt_switch #(.NUM_PORTS(NP), .DATA_W(8), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(0)) dutA (
        .clock(clock), .reset(resetN),
        .mem_en(memEn), .mem_rd_wr(memRdWr), .mem_add(memAdd), .mem_data(memData),
        .mem_rdata(memRdata[0]),
        .data_status(dataStatus), .data_in(dataIn),
        .data_out(dataOut[0]), .out_eop(outEop[0]), .ready(readyV[0]), .read(readReq),
        .drop_cnt(dropCnt[0]), .perr_cnt(perrCnt[0])
    );

    pkt_switch #(.NUM_PORTS(NP), .DATA_W(8), .FIFO_DEPTH(DEPTH), .CHECK_PARITY(1)) dutB (
        .clock(clock), .reset(resetN),
        .mem_en(memEn), .mem_rd_wr(memRdWr), .mem_add(memAdd), .mem_data(memData),
        .mem_rdata(memRdata[1]),
        .data_status(dataStatus), .data_in(dataIn),
        .data_out(dataOut[1]), .out_eop(outEop[1]), .ready(readyV[1]), .read(readReq),
        .drop_cnt(dropCnt[1]), .perr_cnt(perrCnt[1])
    );

    // Shared comparison routine for the model checker and literal checks
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) begin
            nPass++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Committed packet bytes per switch and port as {eop, byte}; the packet in
    // flight is buffered whole and only appended if it survives to its end.
    logic [8:0]  mq [2][NP][$];
    logic [7:0]  mAddr [NP];
    logic [7:0]  mRdata;
    logic [7:0]  mDout [2][NP];
    logic        mEop  [2][NP];
    logic [15:0] mDrop [2];
    logic [15:0] mPerr [2];
    logic [7:0]  pkt [$];
    logic        inPkt;
    logic        ok [2];
    int          tgt;

    always @(posedge clock or negedge resetN) begin
        logic [8:0] e;
        logic [7:0] x;
        logic       hit;
        if (!resetN) begin
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NP; p++) begin
                    mq[d][p].delete();
                    mDout[d][p] = 8'h00;
                    mEop[d][p]  = 1'b0;
                end
                mDrop[d] = 16'h0;
                mPerr[d] = 16'h0;
                ok[d]    = 1'b0;
            end
            for (int p = 0; p < NP; p++) mAddr[p] = 8'h00;
            mRdata = 8'h00;
            inPkt  = 1'b0;
            tgt    = 0;
            pkt.delete();
        end else begin
            if (dataStatus) begin
                if (!inPkt) begin
                    inPkt = 1'b1;
                    pkt.delete();
                    hit = 1'b0;
                    for (int p = NP - 1; p >= 0; p--) begin
                        if (mAddr[p] == dataIn) begin
                            hit = 1'b1;
                            tgt = p;
                        end
                    end
                    for (int d = 0; d < 2; d++) ok[d] = hit;
                end
                // Capacity: committed bytes plus bytes of this packet already stored
                for (int d = 0; d < 2; d++) begin
                    if (ok[d] && (mq[d][tgt].size() + pkt.size() >= DEPTH)) ok[d] = 1'b0;
                end
                pkt.push_back(dataIn);
            end
            for (int d = 0; d < 2; d++) begin
                for (int p = 0; p < NP; p++) begin
                    if (readReq[p] && mq[d][p].size() > 0) begin
                        e = mq[d][p].pop_front();
                        mDout[d][p] = e[7:0];
                        mEop[d][p]  = e[8];
                    end
                end
            end
            if (!dataStatus && inPkt) begin
                inPkt = 1'b0;
                x = 8'h00;
                foreach (pkt[i]) x = x ^ pkt[i];
                for (int d = 0; d < 2; d++) begin
                    if (!ok[d]) begin
                        if (mDrop[d] != 16'hFFFF) mDrop[d] = mDrop[d] + 16'd1;
                    end else if (d == 1 && (x != 8'h00 || pkt.size() < 2)) begin
                        if (mPerr[d] != 16'hFFFF) mPerr[d] = mPerr[d] + 16'd1;
                    end else begin
                        foreach (pkt[i]) mq[d][tgt].push_back({(i == pkt.size() - 1), pkt[i]});
                    end
                end
            end
            if (memEn) begin
                if (memRdWr) begin
                    if (int'(memAdd) < NP) mAddr[memAdd] = memData;
                end else begin
                    mRdata = (int'(memAdd) < NP) ? mAddr[memAdd] : 8'h00;
                end
            end
        end
    end

    // Every-cycle comparison of both switches against the model
    always @(negedge clock) begin
        logic [39:0] expDout;
        logic [4:0]  expEop;
        logic [4:0]  expReady;
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < NP; p++) begin
                expDout[p*8 +: 8] = mDout[d][p];
                expEop[p]         = mEop[d][p];
                expReady[p]       = (mq[d][p].size() != 0);
            end
            checkOutput($sformatf("model ready dut%0d", d), 64'(readyV[d]), 64'(expReady));
            checkOutput($sformatf("model data_out dut%0d", d), 64'(dataOut[d]), 64'(expDout));
            checkOutput($sformatf("model out_eop dut%0d", d), 64'(outEop[d]), 64'(expEop));
            checkOutput($sformatf("model drop_cnt dut%0d", d), 64'(dropCnt[d]), 64'(mDrop[d]));
            checkOutput($sformatf("model perr_cnt dut%0d", d), 64'(perrCnt[d]), 64'(mPerr[d]));
            checkOutput($sformatf("model mem_rdata dut%0d", d), 64'(memRdata[d]), 64'(mRdata));
        end
    end

    // ---------------- stimulus ----------------
    task automatic applyStimulus(input logic ds, input logic [7:0] din, input logic [4:0] rd);
        @(negedge clock);
        dataStatus = ds;
        dataIn     = din;
        readReq    = rd;
    endtask

    // Byte 0 sits in the most significant used byte of 'bytes'
    task automatic sendPacket(input int len, input logic [127:0] bytes, input logic [4:0] rd);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b1, bytes[8*(len-1-i) +: 8], rd);
        end
        applyStimulus(1'b0, 8'h00, rd);
    endtask

    task automatic writeAddr(input logic [2:0] a, input logic [7:0] v);
        @(negedge clock);
        memEn = 1'b1; memRdWr = 1'b1; memAdd = a; memData = v;
        @(negedge clock);
        memEn = 1'b0;
    endtask

    task automatic readAddr(input logic [2:0] a, input logic [7:0] expV);
        @(negedge clock);
        memEn = 1'b1; memRdWr = 1'b0; memAdd = a;
        @(posedge clock);
        #1;
        checkOutput($sformatf("cfg read A[%0d]", a), 64'(memRdata[0]), 64'(expV));
        checkOutput($sformatf("cfg read B[%0d]", a), 64'(memRdata[1]), 64'(expV));
        @(negedge clock);
        memEn = 1'b0;
    endtask

    task automatic popCheck(input logic [4:0] mask, input int port, input logic [7:0] expB, input logic expE);
        applyStimulus(1'b0, 8'h00, mask);
        @(posedge clock);
        #1;
        checkOutput($sformatf("pop A p%0d byte", port), 64'(dataOut[0][port*8 +: 8]), 64'(expB));
        checkOutput($sformatf("pop A p%0d eop", port), 64'(outEop[0][port]), 64'(expE));
    endtask

    initial begin
        resetN = 1'b0; memEn = 1'b0; memRdWr = 1'b0; memAdd = '0; memData = '0;
        dataStatus = 1'b0; dataIn = '0; readReq = '0;
        repeat (3) @(negedge clock);
        checkOutput("reset ready A", 64'(readyV[0]), 64'h0);
        checkOutput("reset data_out A", 64'(dataOut[0]), 64'h0);
        checkOutput("reset drop A", 64'(dropCnt[0]), 64'h0);
        checkOutput("reset perr B", 64'(perrCnt[1]), 64'h0);
        resetN = 1'b1;

        // Port 4 duplicates port 1's address to exercise lowest-index priority
        writeAddr(3'd0, 8'h10);
        writeAddr(3'd1, 8'h20);
        writeAddr(3'd2, 8'h30);
        writeAddr(3'd3, 8'h40);
        writeAddr(3'd4, 8'h20);
        writeAddr(3'd6, 8'h99);
        readAddr(3'd2, 8'h30);
        readAddr(3'd4, 8'h20);
        readAddr(3'd6, 8'h00);

        // Basic routing; bad trailer for the parity-checking switch
        sendPacket(3, 128'h20AABB, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("pkt1 ready A", 64'(readyV[0]), 64'h02);
        checkOutput("pkt1 ready B", 64'(readyV[1]), 64'h00);
        checkOutput("pkt1 perr B", 64'(perrCnt[1]), 64'h1);
        popCheck(5'b00010, 1, 8'h20, 1'b0);
        popCheck(5'b00010, 1, 8'hAA, 1'b0);
        popCheck(5'b00010, 1, 8'hBB, 1'b1);
        applyStimulus(1'b0, 8'h00, 5'b00000);

        // No address match
        sendPacket(1, 128'h55, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("nomatch drop A", 64'(dropCnt[0]), 64'h1);
        checkOutput("nomatch drop B", 64'(dropCnt[1]), 64'h1);
        checkOutput("nomatch ready A", 64'(readyV[0]), 64'h0);

        // Oversized packet, then a normal one to the same port
        sendPacket(10, 128'h10010203040506070809, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("oversize drop A", 64'(dropCnt[0]), 64'h2);
        checkOutput("oversize drop B", 64'(dropCnt[1]), 64'h2);
        checkOutput("oversize ready A", 64'(readyV[0]), 64'h0);
        sendPacket(3, 128'h100111, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("after oversize ready A", 64'(readyV[0]), 64'h01);
        checkOutput("good parity ready B", 64'(readyV[1]), 64'h01);
        popCheck(5'b00001, 0, 8'h10, 1'b0);
        popCheck(5'b00001, 0, 8'h01, 1'b0);
        popCheck(5'b00001, 0, 8'h11, 1'b1);
        applyStimulus(1'b0, 8'h00, 5'b00000);

        // Bad parity: forwarded by A, rejected by B
        sendPacket(3, 128'h100112, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("bad parity perr B", 64'(perrCnt[1]), 64'h2);
        checkOutput("bad parity ready B", 64'(readyV[1]), 64'h0);
        checkOutput("bad parity ready A", 64'(readyV[0]), 64'h01);
        // Reads on all ports: empty ports must hold their last values
        repeat (3) applyStimulus(1'b0, 8'h00, 5'b11111);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("drain ready A", 64'(readyV[0]), 64'h0);
        checkOutput("drain last byte A", 64'(dataOut[0][7:0]), 64'h12);
        checkOutput("hold p1 byte A", 64'(dataOut[0][15:8]), 64'hBB);

        // Drain one packet while the next is written to the same port
        sendPacket(5, 128'h3001020330, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("p2 first ready A", 64'(readyV[0]), 64'h04);
        sendPacket(4, 128'h30050633, 5'b00100);
        popCheck(5'b00100, 2, 8'h30, 1'b0);
        popCheck(5'b00100, 2, 8'h05, 1'b0);
        popCheck(5'b00100, 2, 8'h06, 1'b0);
        popCheck(5'b00100, 2, 8'h33, 1'b1);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("overlap drained A", 64'(readyV[0]), 64'h0);

        // Reset in the middle of a packet with committed data pending
        sendPacket(3, 128'h400141, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("pre-reset ready A", 64'(readyV[0]), 64'h08);
        applyStimulus(1'b1, 8'h10, 5'b00000);
        applyStimulus(1'b1, 8'h77, 5'b00000);
        @(posedge clock);
        #2;
        resetN = 1'b0;
        #1;
        checkOutput("midreset ready A", 64'(readyV[0]), 64'h0);
        checkOutput("midreset ready B", 64'(readyV[1]), 64'h0);
        checkOutput("midreset data_out A", 64'(dataOut[0]), 64'h0);
        checkOutput("midreset out_eop A", 64'(outEop[0]), 64'h0);
        checkOutput("midreset drop A", 64'(dropCnt[0]), 64'h0);
        checkOutput("midreset perr B", 64'(perrCnt[1]), 64'h0);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        @(negedge clock);
        resetN = 1'b1;
        readAddr(3'd0, 8'h00);
        sendPacket(3, 128'h005A5A, 5'b00000);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        checkOutput("post-reset ready A", 64'(readyV[0]), 64'h01);
        checkOutput("post-reset ready B", 64'(readyV[1]), 64'h01);
        popCheck(5'b00001, 0, 8'h00, 1'b0);
        popCheck(5'b00001, 0, 8'h5A, 1'b0);
        popCheck(5'b00001, 0, 8'h5A, 1'b1);
        applyStimulus(1'b0, 8'h00, 5'b00000);
        repeat (2) @(negedge clock);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] time limit");
    end

endmodule
